matrix_feeder: RTL and testbench

MATRIX_FEEDER -- requirements
Module: matrix_feeder

---
 rtl/matrix_feeder.sv | 128 ++++++++++++
 tb/tb_matrix_feeder.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_feeder.sv
// Buffers N k-slices, then streams them as N beats (plus N-1 zero flush beats when
// MATRIX_FEEDER_FLUSH_EN is defined) to the skewer; first beat one cycle after the last load; stall freezes streaming.
module matrix_feeder #(
  parameter int MATRIX_SIZE = 2,
  parameter int DATA_SIZE   = 32
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] in_data,
  input  logic                                  stall,
  output logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] out_data,
  output logic                                  out_enable,
  output logic                                  done
);

  localparam int            CW   = $clog2(2 * MATRIX_SIZE) + 1;
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] LAST = CW'(MATRIX_SIZE - 1);
`ifdef MATRIX_FEEDER_FLUSH_EN
  localparam logic [CW-1:0] FLUSH_LAST = CW'((MATRIX_SIZE > 1) ? MATRIX_SIZE - 2 : 0);
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
`ifdef MATRIX_FEEDER_FLUSH_EN
    FLUSH  = 2'd2,
`endif
    DONE   = 2'd3
  } state_t;

  typedef logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] slice_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  slice_t        mem_q [MATRIX_SIZE];
  slice_t        mem_d [MATRIX_SIZE];
  slice_t        rd_slice;

  // Slot select by compare rather than indexing: cnt is wider than the slot index.
  always_comb begin
    rd_slice = '0;
    for (int i = 0; i < MATRIX_SIZE; i++) begin
      if (cnt_q == CW'(i)) rd_slice = mem_q[i];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mem_d   = mem_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          for (int i = 0; i < MATRIX_SIZE; i++) begin
            if (cnt_q == CW'(i)) mem_d[i] = in_data;
          end
          if (cnt_q == LAST) begin
            state_d = STREAM;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
      end
      STREAM: begin
        if (!stall) begin
          if (cnt_q == LAST) begin
            cnt_d = '0;
`ifdef MATRIX_FEEDER_FLUSH_EN
            if (MATRIX_SIZE > 1) state_d = FLUSH;
            else                 state_d = DONE;
`else
            state_d = DONE;
`endif
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
      end
`ifdef MATRIX_FEEDER_FLUSH_EN
      FLUSH: begin
        if (!stall) begin
          if (cnt_q == FLUSH_LAST) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
      end
`endif
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mem_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mem_q   <= mem_d;
    end
  end

  // Outputs decode registered state; out_enable also follows same-cycle stall.
  assign in_ready = (state_q == IDLE);
  assign done     = (state_q == DONE);
  assign out_data = (state_q == STREAM) ? rd_slice : '0;
`ifdef MATRIX_FEEDER_FLUSH_EN
  assign out_enable = ((state_q == STREAM) || (state_q == FLUSH)) && !stall;
`else
  assign out_enable = (state_q == STREAM) && !stall;
`endif

endmodule

// File: tb/tb_matrix_feeder.sv
// Randomized bench for matrix_feeder: N=4 and N=1 instances against a beat-queue model.
module tb_matrix_feeder;

`ifdef MATRIX_FEEDER_FLUSH_EN
  localparam bit FLUSH = 1'b1;
`else
  localparam bit FLUSH = 1'b0;
`endif
  localparam int BEATS4 = FLUSH ? 7 : 4;

  typedef logic [3:0][31:0] slice4_t;
  typedef logic [0:0][31:0] slice1_t;

  logic    clk;
  logic    rst;
  logic    v4, r4, s4, oe4, dn4;
  slice4_t d4, od4;
  logic    v1, r1, s1, oe1, dn1;
  slice1_t d1, od1;

  int total;
  int bad;

  matrix_feeder #(.MATRIX_SIZE(4), .DATA_SIZE(32)) dut4 (
    .clk(clk), .reset(rst), .in_valid(v4), .in_ready(r4), .in_data(d4),
    .stall(s4), .out_data(od4), .out_enable(oe4), .done(dn4)
  );

  matrix_feeder #(.MATRIX_SIZE(1), .DATA_SIZE(32)) dut1 (
    .clk(clk), .reset(rst), .in_valid(v1), .in_ready(r1), .in_data(d1),
    .stall(s1), .out_data(od1), .out_enable(oe1), .done(dn1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic slice4_t rand_slice();
    slice4_t r;
    for (int i = 0; i < 4; i++) r[i] = $urandom;
    return r;
  endfunction

  // One full operation on dut4: load 4 slices, then stream and compare against the beat queue.
  task automatic run_op(input int gap_pct, input int stall_pct, input int hold_at,
                        input int hold_len, input int abort_at,
                        output int n_en, output int n_cyc);
    slice4_t exp_q[$];
    slice4_t s;
    int      got, lcyc, pops, held;
    bit      st, fin;
    got = 0; lcyc = 0; pops = 0; held = 0; fin = 0; n_en = 0; n_cyc = 0;
    while (got < 4 && lcyc < 100) begin
      @(negedge clk);
      s  = rand_slice();
      v4 = ($urandom_range(99) >= gap_pct);
      d4 = s;
      s4 = 1'($urandom_range(1));
      #1; lcyc++; total++;
      if (r4 !== 1'b1 || oe4 !== 1'b0 || od4 !== '0 || dn4 !== 1'b0) begin
        bad++;
        $display("FAIL load_idle: ready=%b en=%b data=%h done=%b, want ready=1 en=0 data=0 done=0",
                 r4, oe4, od4, dn4);
      end
      if (v4) begin
        exp_q.push_back(s);
        got++;
      end
    end
    total++;
    if (got != 4) begin
      bad++;
      $display("FAIL load_timeout: handshakes=%0d, want 4", got);
    end
    if (FLUSH) repeat (3) exp_q.push_back('0);

    while (!fin && n_cyc < 100) begin
      @(negedge clk);
      v4 = 1'($urandom_range(1));
      d4 = rand_slice();
      if (pops == hold_at && held < hold_len) begin
        st = 1'b1;
        held++;
      end else begin
        st = ($urandom_range(99) < stall_pct);
      end
      s4 = st;
      #1; n_cyc++; total++;
      if (exp_q.size() == 0) begin
        fin = 1'b1;
        if (dn4 !== 1'b1 || oe4 !== 1'b0 || od4 !== '0 || r4 !== 1'b0) begin
          bad++;
          $display("FAIL done_cycle: done=%b en=%b data=%h ready=%b, want done=1 en=0 data=0 ready=0",
                   dn4, oe4, od4, r4);
        end
      end else begin
        if (dn4 !== 1'b0 || r4 !== 1'b0 || oe4 !== !st || od4 !== exp_q[0]) begin
          bad++;
          $display("FAIL beat%0d: done=%b ready=%b en=%b data=%h, want done=0 ready=0 en=%b data=%h",
                   pops, dn4, r4, oe4, od4, !st, exp_q[0]);
        end
        if (oe4 === 1'b1) n_en++;
        if (abort_at == pops) begin
          #1 rst = 1'b1;
          #1; total++;
          if (r4 !== 1'b1 || oe4 !== 1'b0 || od4 !== '0 || dn4 !== 1'b0) begin
            bad++;
            $display("FAIL abort_reset: ready=%b en=%b data=%h done=%b, want ready=1 en=0 data=0 done=0",
                     r4, oe4, od4, dn4);
          end
          return;
        end
        if (!st) begin
          void'(exp_q.pop_front());
          pops++;
        end
      end
    end
    total++;
    if (!fin) begin
      bad++;
      $display("FAIL done_timeout: no done after %0d stream cycles, beats left=%0d", n_cyc, exp_q.size());
    end
    @(negedge clk);
    v4 = 1'b0; s4 = 1'b0;
    #1; total++;
    if (r4 !== 1'b1 || oe4 !== 1'b0 || dn4 !== 1'b0) begin
      bad++;
      $display("FAIL idle_return: ready=%b en=%b done=%b, want ready=1 en=0 done=0", r4, oe4, dn4);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1; total++;
    if (r4 !== 1'b1 || oe4 !== 1'b0 || od4 !== '0 || dn4 !== 1'b0 ||
        r1 !== 1'b1 || oe1 !== 1'b0 || od1 !== '0 || dn1 !== 1'b0) begin
      bad++;
      $display("FAIL reset_held: n4 r/e/d/done=%b%b%h%b n1=%b%b%h%b, want 1,0,0,0",
               r4, oe4, od4, dn4, r1, oe1, od1, dn1);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1; total++;
    if (r4 !== 1'b1 || oe4 !== 1'b0 || od4 !== '0 || dn4 !== 1'b0 ||
        r1 !== 1'b1 || oe1 !== 1'b0 || od1 !== '0 || dn1 !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: n4 r/e/d/done=%b%b%h%b n1=%b%b%h%b, want 1,0,0,0",
               r4, oe4, od4, dn4, r1, oe1, od1, dn1);
    end
  endtask

  task automatic test_basic();
    int en, cyc;
    run_op(0, 0, -1, 0, -1, en, cyc);
    total++;
    if (en != BEATS4 || cyc != BEATS4 + 1) begin
      bad++;
      $display("FAIL basic_counts: enabled=%0d cycles_to_done=%0d, want %0d and %0d",
               en, cyc, BEATS4, BEATS4 + 1);
    end
  endtask

  task automatic test_random();
    int en, cyc;
    for (int k = 0; k < 10; k++) begin
      run_op($urandom_range(60), $urandom_range(40), -1, 0, -1, en, cyc);
      total++;
      if (en != BEATS4) begin
        bad++;
        $display("FAIL random_enabled op%0d: enabled=%0d, want %0d", k, en, BEATS4);
      end
    end
  endtask

  task automatic test_stall();
    int en, cyc;
    run_op(0, 0, 1, 2, -1, en, cyc);
    total++;
    if (en != BEATS4 || cyc != BEATS4 + 3) begin
      bad++;
      $display("FAIL stall_counts: enabled=%0d cycles_to_done=%0d, want %0d and %0d",
               en, cyc, BEATS4, BEATS4 + 3);
    end
  endtask

  task automatic test_reset_mid();
    int en, cyc;
    run_op(0, 0, -1, 0, 1, en, cyc);
    @(negedge clk);
    #1; total++;
    if (r4 !== 1'b1 || oe4 !== 1'b0 || dn4 !== 1'b0) begin
      bad++;
      $display("FAIL abort_hold: ready=%b en=%b done=%b, want ready=1 en=0 done=0", r4, oe4, dn4);
    end
    rst = 1'b0; v4 = 1'b0; s4 = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1; total++;
      if (dn4 !== 1'b0 || r4 !== 1'b1 || oe4 !== 1'b0) begin
        bad++;
        $display("FAIL abort_quiet c%0d: done=%b ready=%b en=%b, want done=0 ready=1 en=0",
                 c, dn4, r4, oe4);
      end
    end
    run_op(40, 0, -1, 0, -1, en, cyc);
    total++;
    if (en != BEATS4) begin
      bad++;
      $display("FAIL abort_reload: enabled=%0d, want %0d", en, BEATS4);
    end
  endtask

  task automatic test_n1();
    slice1_t val;
    val = '0;
    val[0] = $urandom;
    @(negedge clk);
    v1 = 1'b1; d1 = val; s1 = 1'b0;
    #1; total++;
    if (r1 !== 1'b1 || oe1 !== 1'b0 || dn1 !== 1'b0) begin
      bad++;
      $display("FAIL n1_load: ready=%b en=%b done=%b, want 1 0 0", r1, oe1, dn1);
    end
    @(negedge clk);
    d1 = ~val; s1 = 1'b1;
    #1; total++;
    if (r1 !== 1'b0 || oe1 !== 1'b0 || od1 !== val || dn1 !== 1'b0) begin
      bad++;
      $display("FAIL n1_stalled: ready=%b en=%b data=%h done=%b, want 0 0 %h 0", r1, oe1, od1, dn1, val);
    end
    @(negedge clk);
    s1 = 1'b0;
    #1; total++;
    if (r1 !== 1'b0 || oe1 !== 1'b1 || od1 !== val || dn1 !== 1'b0) begin
      bad++;
      $display("FAIL n1_beat: ready=%b en=%b data=%h done=%b, want 0 1 %h 0", r1, oe1, od1, dn1, val);
    end
    @(negedge clk);
    v1 = 1'b0;
    #1; total++;
    if (dn1 !== 1'b1 || oe1 !== 1'b0 || od1 !== '0 || r1 !== 1'b0) begin
      bad++;
      $display("FAIL n1_done: done=%b en=%b data=%h ready=%b, want 1 0 0 0", dn1, oe1, od1, r1);
    end
    @(negedge clk);
    #1; total++;
    if (dn1 !== 1'b0 || r1 !== 1'b1 || oe1 !== 1'b0) begin
      bad++;
      $display("FAIL n1_idle: done=%b ready=%b en=%b, want 0 1 0", dn1, r1, oe1);
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1;
    v4 = 1'b0; s4 = 1'b0; d4 = '0;
    v1 = 1'b0; s1 = 1'b0; d1 = '0;
    test_reset();
    test_basic();
    test_stall();
    test_random();
    test_reset_mid();
    test_n1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
